// File: rtl/param_rs.sv
// param_rs: parametrised reservation station with CDB wakeup, dispatch bypass,
// oldest-first selection and a ready/valid issue register.
module param_rs #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NUM_CDB = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned OP_W    = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         clear,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   free_count,
  input  logic                         dispatch_valid,
  input  logic [OP_W-1:0]              dispatch_op,
  input  logic [DATA_W-1:0]            dispatch_imm,
  input  logic [ADDR_W-1:0]            dispatch_pc,
  input  logic                         dispatch_reg1_valid,
  input  logic [DATA_W-1:0]            dispatch_reg1_data,
  input  logic [TAG_W-1:0]             dispatch_reg1_tag,
  input  logic                         dispatch_reg2_valid,
  input  logic [DATA_W-1:0]            dispatch_reg2_data,
  input  logic [TAG_W-1:0]             dispatch_reg2_tag,
  input  logic [TAG_W-1:0]             dispatch_reg_dest_tag,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]    cdb_data,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [OP_W-1:0]              issue_op,
  output logic [DATA_W-1:0]            issue_reg1,
  output logic [DATA_W-1:0]            issue_reg2,
  output logic [DATA_W-1:0]            issue_imm,
  output logic [ADDR_W-1:0]            issue_pc,
  output logic [TAG_W-1:0]             issue_dest_tag
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] pc;
    logic [TAG_W-1:0]  dest;
    logic              r1_valid;
    logic [DATA_W-1:0] r1_data;
    logic [TAG_W-1:0]  r1_tag;
    logic              r2_valid;
    logic [DATA_W-1:0] r2_data;
    logic [TAG_W-1:0]  r2_tag;
  } entry_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] pc;
    logic [TAG_W-1:0]  dest;
  } issue_t;

  entry_t           ent_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  // older_q[i][j] set means entry j was dispatched before entry i
  logic [DEPTH-1:0] older_q [DEPTH];

  logic [DATA_W:0]  wk1 [DEPTH];
  logic [DATA_W:0]  wk2 [DEPTH];
  logic [DATA_W:0]  byp1;
  logic [DATA_W:0]  byp2;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] sel_oh;
  logic             any_ready;
  issue_t           sel_pay;
  logic [IDX_W-1:0] free_idx;
  entry_t           disp_ent;
  logic             do_disp;
  logic             issue_load;
  logic             do_issue;
  logic [DEPTH-1:0] valid_nxt;

  // Lowest-index active CDB channel carrying tag; MSB is the hit flag.
  function automatic logic [DATA_W:0] cdb_match(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        vld,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] datas
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
        r = {1'b1, datas[k*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  // CDB lookups for every stored operand and for the dispatching op.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = cdb_match(ent_q[i].r1_tag, cdb_valid, cdb_tag, cdb_data);
      wk2[i] = cdb_match(ent_q[i].r2_tag, cdb_valid, cdb_tag, cdb_data);
    end
    byp1 = cdb_match(dispatch_reg1_tag, cdb_valid, cdb_tag, cdb_data);
    byp2 = cdb_match(dispatch_reg2_tag, cdb_valid, cdb_tag, cdb_data);
  end

  // Entries with both operands captured (pre-edge state only).
  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i] & ent_q[i].r1_valid & ent_q[i].r2_valid;
    end
  end

  // Oldest-ready pick, its payload, and the lowest free slot.
  always_comb begin
    sel_oh   = '0;
    sel_pay  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = ready[i] & ~(|(older_q[i] & ready));
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        sel_pay.op   = ent_q[i].op;
        sel_pay.reg1 = ent_q[i].r1_data;
        sel_pay.reg2 = ent_q[i].r2_data;
        sel_pay.imm  = ent_q[i].imm;
        sel_pay.pc   = ent_q[i].pc;
        sel_pay.dest = ent_q[i].dest;
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Dispatch entry with same-cycle CDB bypass applied to pending operands.
  always_comb begin
    disp_ent          = '0;
    disp_ent.op       = dispatch_op;
    disp_ent.imm      = dispatch_imm;
    disp_ent.pc       = dispatch_pc;
    disp_ent.dest     = dispatch_reg_dest_tag;
    disp_ent.r1_tag   = dispatch_reg1_tag;
    disp_ent.r2_tag   = dispatch_reg2_tag;
    disp_ent.r1_valid = dispatch_reg1_valid | byp1[DATA_W];
    disp_ent.r1_data  = dispatch_reg1_valid ? dispatch_reg1_data : byp1[DATA_W-1:0];
    disp_ent.r2_valid = dispatch_reg2_valid | byp2[DATA_W];
    disp_ent.r2_data  = dispatch_reg2_valid ? dispatch_reg2_data : byp2[DATA_W-1:0];
  end

  assign full       = &valid_q;
  assign any_ready  = |ready;
  assign do_disp    = dispatch_valid & ~full;
  assign issue_load = ~issue_valid | issue_ready;
  assign do_issue   = issue_load & any_ready;

  // Occupancy after this edge: issued slot freed, dispatched slot taken.
  always_comb begin
    valid_nxt = valid_q & ~(do_issue ? sel_oh : '0);
    if (do_disp) valid_nxt[free_idx] = 1'b1;
  end

  // Entry array, age matrix, free counter and issue register.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_q        <= '0;
      free_count     <= CNT_W'(DEPTH);
      issue_valid    <= 1'b0;
      issue_op       <= '0;
      issue_reg1     <= '0;
      issue_reg2     <= '0;
      issue_imm      <= '0;
      issue_pc       <= '0;
      issue_dest_tag <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !ent_q[i].r1_valid && wk1[i][DATA_W]) begin
          ent_q[i].r1_valid <= 1'b1;
          ent_q[i].r1_data  <= wk1[i][DATA_W-1:0];
        end
        if (valid_q[i] && !ent_q[i].r2_valid && wk2[i][DATA_W]) begin
          ent_q[i].r2_valid <= 1'b1;
          ent_q[i].r2_data  <= wk2[i][DATA_W-1:0];
        end
        if (do_disp) older_q[i][free_idx] <= 1'b0;
      end
      if (do_disp) begin
        ent_q[free_idx]   <= disp_ent;
        older_q[free_idx] <= valid_q;
      end
      valid_q    <= valid_nxt;
      free_count <= free_count + CNT_W'(do_issue) - CNT_W'(do_disp);
      if (issue_load) begin
        issue_valid <= any_ready;
        if (any_ready) begin
          issue_op       <= sel_pay.op;
          issue_reg1     <= sel_pay.reg1;
          issue_reg2     <= sel_pay.reg2;
          issue_imm      <= sel_pay.imm;
          issue_pc       <= sel_pay.pc;
          issue_dest_tag <= sel_pay.dest;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_rs.sv
// tb_param_rs: directed plus randomized checks of param_rs against an
// age-ordered queue model of the reservation station.
module tb_param_rs;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned NUM_CDB = 4;

  logic         clk;
  logic         rst, rdy, clear;
  logic         full;
  logic [3:0]   free_count;
  logic         dispatch_valid;
  logic [5:0]   dispatch_op;
  logic [31:0]  dispatch_imm, dispatch_pc;
  logic         dispatch_reg1_valid, dispatch_reg2_valid;
  logic [31:0]  dispatch_reg1_data, dispatch_reg2_data;
  logic [3:0]   dispatch_reg1_tag, dispatch_reg2_tag, dispatch_reg_dest_tag;
  logic [3:0]   cdb_valid;
  logic [15:0]  cdb_tag;
  logic [127:0] cdb_data;
  logic         issue_valid, issue_ready;
  logic [5:0]   issue_op;
  logic [31:0]  issue_reg1, issue_reg2, issue_imm, issue_pc;
  logic [3:0]   issue_dest_tag;

  param_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .full(full), .free_count(free_count),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
    .dispatch_imm(dispatch_imm), .dispatch_pc(dispatch_pc),
    .dispatch_reg1_valid(dispatch_reg1_valid), .dispatch_reg1_data(dispatch_reg1_data),
    .dispatch_reg1_tag(dispatch_reg1_tag),
    .dispatch_reg2_valid(dispatch_reg2_valid), .dispatch_reg2_data(dispatch_reg2_data),
    .dispatch_reg2_tag(dispatch_reg2_tag),
    .dispatch_reg_dest_tag(dispatch_reg_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_reg1(issue_reg1), .issue_reg2(issue_reg2),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_dest_tag(issue_dest_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: entries kept in dispatch order ----
  typedef struct {
    logic [5:0]  op;
    logic [31:0] imm, pc;
    logic [3:0]  dest;
    bit          v1;
    logic [31:0] d1;
    logic [3:0]  t1;
    bit          v2;
    logic [31:0] d2;
    logic [3:0]  t2;
  } m_ent_t;

  m_ent_t      mq[$];
  bit          m_iv = 1'b0;
  logic [5:0]  m_op = '0;
  logic [31:0] m_r1 = '0, m_r2 = '0, m_imm = '0, m_pc = '0;
  logic [3:0]  m_dest = '0;

  function automatic bit m_cdb(input logic [3:0] tag, output logic [31:0] d);
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && cdb_tag[k*4 +: 4] == tag) begin
        d = cdb_data[k*32 +: 32];
        return 1'b1;
      end
    end
    d = '0;
    return 1'b0;
  endfunction

  int          pick;
  bit          was_full;
  m_ent_t      me;
  logic [31:0] md;

  always @(posedge clk) begin
    if (rst || clear) begin
      mq.delete();
      m_iv = 1'b0; m_op = '0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_pc = '0; m_dest = '0;
    end else if (rdy) begin
      was_full = (mq.size() == DEPTH);
      pick = -1;
      for (int i = 0; i < mq.size(); i++)
        if (pick < 0 && mq[i].v1 && mq[i].v2) pick = i;
      if (!m_iv || issue_ready) begin
        if (pick >= 0) begin
          m_iv = 1'b1; m_op = mq[pick].op; m_r1 = mq[pick].d1; m_r2 = mq[pick].d2;
          m_imm = mq[pick].imm; m_pc = mq[pick].pc; m_dest = mq[pick].dest;
          mq.delete(pick);
        end else begin
          m_iv = 1'b0;
        end
      end
      for (int i = 0; i < mq.size(); i++) begin
        me = mq[i];
        if (!me.v1 && m_cdb(me.t1, md)) begin me.v1 = 1'b1; me.d1 = md; end
        if (!me.v2 && m_cdb(me.t2, md)) begin me.v2 = 1'b1; me.d2 = md; end
        mq[i] = me;
      end
      if (dispatch_valid && !was_full) begin
        me.op = dispatch_op; me.imm = dispatch_imm; me.pc = dispatch_pc;
        me.dest = dispatch_reg_dest_tag;
        me.t1 = dispatch_reg1_tag; me.t2 = dispatch_reg2_tag;
        me.v1 = dispatch_reg1_valid; me.d1 = dispatch_reg1_data;
        me.v2 = dispatch_reg2_valid; me.d2 = dispatch_reg2_data;
        if (!me.v1 && m_cdb(me.t1, md)) begin me.v1 = 1'b1; me.d1 = md; end
        if (!me.v2 && m_cdb(me.t2, md)) begin me.v2 = 1'b1; me.d2 = md; end
        mq.push_back(me);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("full", 64'(full), 64'(mq.size() == DEPTH));
      check("free_count", 64'(free_count), 64'(DEPTH - mq.size()));
      check("issue_valid", 64'(issue_valid), 64'(m_iv));
      check("issue_op", 64'(issue_op), 64'(m_op));
      check("issue_reg1", 64'(issue_reg1), 64'(m_r1));
      check("issue_reg2", 64'(issue_reg2), 64'(m_r2));
      check("issue_imm", 64'(issue_imm), 64'(m_imm));
      check("issue_pc", 64'(issue_pc), 64'(m_pc));
      check("issue_dest", 64'(issue_dest_tag), 64'(m_dest));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = '0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] pc,
                      input bit v1, input logic [31:0] d1, input logic [3:0] t1,
                      input bit v2, input logic [31:0] d2, input logic [3:0] t2,
                      input logic [3:0] dest);
    dispatch_valid = 1'b1;
    dispatch_op = op; dispatch_imm = {26'd0, op}; dispatch_pc = pc;
    dispatch_reg1_valid = v1; dispatch_reg1_data = d1; dispatch_reg1_tag = t1;
    dispatch_reg2_valid = v2; dispatch_reg2_data = d2; dispatch_reg2_tag = t2;
    dispatch_reg_dest_tag = dest;
  endtask

  task automatic set_cdb(input int ch, input logic [3:0] tag, input logic [31:0] data);
    cdb_valid[ch] = 1'b1;
    cdb_tag[ch*4 +: 4] = tag;
    cdb_data[ch*32 +: 32] = data;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; issue_ready = 1'b1;
    dispatch_valid = 1'b0; dispatch_op = '0; dispatch_imm = '0; dispatch_pc = '0;
    dispatch_reg1_valid = 1'b0; dispatch_reg1_data = '0; dispatch_reg1_tag = '0;
    dispatch_reg2_valid = 1'b0; dispatch_reg2_data = '0; dispatch_reg2_tag = '0;
    dispatch_reg_dest_tag = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    step(); step();
    rst = 1'b0;
    check("reset issue_valid", 64'(issue_valid), 64'd0);
    check("reset free_count", 64'(free_count), 64'd8);
    check("reset full", 64'(full), 64'd0);
    check("reset issue_reg1", 64'(issue_reg1), 64'd0);
    chk_en = 1'b1;

    // Both operands present: issues one edge after dispatch.
    disp(6'h12, 32'h100, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
    step(); idle();
    check("t1 free after dispatch", 64'(free_count), 64'd7);
    check("t1 not yet issued", 64'(issue_valid), 64'd0);
    step();
    check("t1 issue_valid", 64'(issue_valid), 64'd1);
    check("t1 reg1", 64'(issue_reg1), 64'd5);
    check("t1 reg2", 64'(issue_reg2), 64'd7);
    check("t1 dest", 64'(issue_dest_tag), 64'd3);
    check("t1 op", 64'(issue_op), 64'h12);
    check("t1 pc", 64'(issue_pc), 64'h100);
    check("t1 free restored", 64'(free_count), 64'd8);

    // Wakeup with two matching channels: lower index wins.
    disp(6'h21, 32'h104, 1'b0, 32'd0, 4'd2, 1'b1, 32'h11, 4'd0, 4'd4);
    step(); idle();
    step(); step();
    set_cdb(1, 4'd2, 32'hAA);
    set_cdb(2, 4'd2, 32'hBB);
    step(); idle();
    check("t2 not issued at wakeup", 64'(issue_valid), 64'd0);
    step();
    check("t2 issue_valid", 64'(issue_valid), 64'd1);
    check("t2 reg1 lowest channel", 64'(issue_reg1), 64'hAA);
    check("t2 reg2", 64'(issue_reg2), 64'h11);

    // Same-cycle bypass at dispatch.
    disp(6'h22, 32'h108, 1'b1, 32'h33, 4'd0, 1'b0, 32'd0, 4'd5, 4'd5);
    set_cdb(3, 4'd5, 32'h55);
    step(); idle();
    check("t3 not issued at dispatch", 64'(issue_valid), 64'd0);
    step();
    check("t3 issue_valid", 64'(issue_valid), 64'd1);
    check("t3 reg2 bypass", 64'(issue_reg2), 64'h55);
    check("t3 reg1", 64'(issue_reg1), 64'h33);
    step();

    // Fill all entries A..H with pending src1 tags 0..7.
    for (int k = 0; k < 8; k++) begin
      disp(6'(k), 32'(32'h200 + 4*k), 1'b0, 32'd0, 4'(k), 1'b1, 32'(k), 4'd0, 4'(8 + k));
      step();
    end
    idle();
    check("t4 full", 64'(full), 64'd1);
    check("t4 free zero", 64'(free_count), 64'd0);
    disp(6'h3F, 32'h300, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'hF);
    step(); idle();
    check("t4 ninth ignored", 64'(free_count), 64'd0);
    issue_ready = 1'b0;
    set_cdb(0, 4'd7, 32'h77);
    step(); idle();
    set_cdb(0, 4'd2, 32'h22);
    step(); idle();
    check("t4 H issued", 64'(issue_dest_tag), 64'd15);
    check("t4 H reg1", 64'(issue_reg1), 64'h77);
    check("t4 free after H", 64'(free_count), 64'd1);
    step();
    check("t4 H held", 64'(issue_dest_tag), 64'd15);
    check("t4 H held valid", 64'(issue_valid), 64'd1);
    issue_ready = 1'b1;
    step();
    check("t4 C issued", 64'(issue_dest_tag), 64'd10);
    check("t4 C reg1", 64'(issue_reg1), 64'h22);
    check("t4 free after C", 64'(free_count), 64'd2);

    // Clear with three entries ready.
    set_cdb(0, 4'd0, 32'hA0);
    set_cdb(1, 4'd1, 32'hB0);
    set_cdb(2, 4'd3, 32'hD0);
    step(); idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5 issue_valid", 64'(issue_valid), 64'd0);
    check("t5 free", 64'(free_count), 64'd8);
    step(); step();
    check("t5 no issue after clear", 64'(issue_valid), 64'd0);

    // rdy low during a broadcast: nothing captured, nothing moves.
    disp(6'h05, 32'h400, 1'b0, 32'd0, 4'd9, 1'b1, 32'h6, 4'd0, 4'd6);
    step(); idle();
    rdy = 1'b0;
    set_cdb(0, 4'd9, 32'h99);
    disp(6'h06, 32'h404, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd7);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t6 frozen free", 64'(free_count), 64'd7);
      check("t6 frozen issue", 64'(issue_valid), 64'd0);
    end
    rdy = 1'b1; idle();
    step(); step(); step();
    check("t6 no stale capture", 64'(issue_valid), 64'd0);
    set_cdb(0, 4'd9, 32'h99);
    step(); idle();
    step();
    check("t6 rebroadcast issue", 64'(issue_valid), 64'd1);
    check("t6 rebroadcast reg1", 64'(issue_reg1), 64'h99);

    // Randomized traffic checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      rdy         = ($urandom_range(0, 9) != 0);
      clear       = ($urandom_range(0, 99) == 0);
      issue_ready = ($urandom_range(0, 9) < 7);
      dispatch_valid        = ($urandom_range(0, 9) < 6);
      dispatch_op           = 6'($urandom);
      dispatch_imm          = $urandom;
      dispatch_pc           = $urandom;
      dispatch_reg1_valid   = $urandom_range(0, 1) == 1;
      dispatch_reg1_data    = $urandom;
      dispatch_reg1_tag     = 4'($urandom_range(0, 7));
      dispatch_reg2_valid   = $urandom_range(0, 1) == 1;
      dispatch_reg2_data    = $urandom;
      dispatch_reg2_tag     = 4'($urandom_range(0, 7));
      dispatch_reg_dest_tag = 4'($urandom);
      for (int c = 0; c < NUM_CDB; c++) begin
        cdb_valid[c]       = ($urandom_range(0, 3) == 0);
        cdb_tag[c*4 +: 4]  = 4'($urandom_range(0, 7));
        cdb_data[c*32 +: 32] = $urandom;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_rs.md
Name: param_rs

Overview:
- Parametrised reservation station for the out-of-order core. Generalises the fixed-size branch RS so one block serves the ALU, branch and LSU front ends.
- Holds dispatched ops until both source operands are captured from the CDB channels, then issues the oldest ready entry to its functional unit.
- Adds three things the fixed-size RS lacks: ready/valid backpressure from the FU, same-cycle CDB bypass at dispatch, and oldest-first selection.

Parameters:
DEPTH, 8, number of entries (power of two, 2..32)
NUM_CDB, 4, number of CDB broadcast channels; index 0 has highest priority
DATA_W, 32, operand/immediate width
ADDR_W, 32, pc width
TAG_W, 4, ROB tag width
OP_W, 6, opcode width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low, all state and outputs hold
clear  in  1  synchronous flush (mispredict), same effect as rst
full  out  1  combinational; high when 0 free entries
free_count  out  $clog2(DEPTH+1)  registered count of free entries
dispatch_valid  in  1  dispatch request
dispatch_op  in  OP_W  opcode
dispatch_imm  in  DATA_W  immediate
dispatch_pc  in  ADDR_W  instruction pc
dispatch_reg1_valid  in  1  src1 value present
dispatch_reg1_data  in  DATA_W  src1 value
dispatch_reg1_tag  in  TAG_W  src1 producer tag
dispatch_reg2_valid/_data/_tag  in  1/DATA_W/TAG_W  src2, same meaning
dispatch_reg_dest_tag  in  TAG_W  destination ROB tag
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  channel k at [k*TAG_W +: TAG_W]
cdb_data  in  NUM_CDB*DATA_W  channel k at [k*DATA_W +: DATA_W]
issue_valid  out  1  issue register holds an op
issue_ready  in  1  FU accepts op this cycle
issue_op/_reg1/_reg2/_imm/_pc/_dest_tag  out  OP_W/DATA_W/DATA_W/DATA_W/ADDR_W/TAG_W  issued payload

Behaviour:
- Reset/clear:
  - All entries invalid; free_count=DEPTH; full=0.
  - issue_valid=0; all issue_* payload outputs = 0.
  - clear has priority over dispatch, wakeup and issue in the same cycle.
- rdy=0: no state change, including the issue register; issue_ready is ignored.
- Wakeup:
  - Each cycle, every valid entry with an invalid operand compares its tag against every channel with cdb_valid high.
  - On a match, the operand becomes valid and captures the data.
  - Multiple matching channels: lowest index wins.
  - src1 and src2 wake independently and may wake in the same cycle.
- Dispatch:
  - Accepted when dispatch_valid=1 and full=0; silently ignored when full=1.
  - Writes the lowest-index free entry.
  - Bypass: an operand dispatched invalid whose tag matches an active CDB channel in the same cycle is stored as valid with the CDB data.
- Age:
  - Each entry records dispatch order.
  - Among ready entries (both operands valid), the earliest dispatched is selected. Index is never a tiebreak, because ages are unique.
- Issue register:
  - Loads when issue_valid=0, or when issue_valid=1 and issue_ready=1.
  - On load: if any entry is ready, load the oldest, free that entry, and set issue_valid=1. Otherwise set issue_valid=0.
  - When issue_valid=1 and issue_ready=0, the payload holds stable and no entry is freed.
- Latency:
  - Dispatch with both operands ready, or bypassed, at edge N: issue_valid=1 after edge N+1.
  - Wakeup at edge N: issue_valid=1 after edge N+1.
- Readiness is evaluated on pre-edge state, so an entry cannot be dispatched and issued on the same edge.
- Simultaneous free and dispatch:
  - Allowed; free_count updates as +freed −dispatched.
  - full is computed from current state only, so a slot freed this edge is usable next cycle.
- Throughput: at most one dispatch and one issue per cycle. Sustained rate is 1 op/cycle with issue_ready tied high.

Test Plan:
- Reset, then dispatch op=0x12 with src1=5 and src2=7 both valid (pc=0x100, dest=3) at cycle 1 -> after cycle 2 edge: issue_valid=1, reg1=5, reg2=7, dest_tag=3; free_count returns to 8.
- Dispatch with src1 tag=2 invalid; 3 cycles later cdb_valid=4'b0110 with ch1 tag=2 data=0xAA and ch2 tag=2 data=0xBB -> reg1=0xAA, issued one cycle after the wakeup.
- Dispatch with src2 tag=5 while cdb ch3 broadcasts tag=5 data=0x55 in the same cycle -> entry stored ready, issues next cycle with reg2=0x55.
- Fill 8 entries with pending operands (dispatch order A..H), then wake H first and C one cycle later, holding issue_ready=0 for 2 cycles -> full=1, 9th dispatch ignored; H issued and held stable until ready, then C issues; free_count increments per accept.
- With 3 entries ready and issue_ready=1, assert clear -> next cycle issue_valid=0, free_count=8, no further issues.
- Hold rdy=0 for 4 cycles during a CDB broadcast -> no capture and outputs frozen; after rdy=1, the same tag is captured only if rebroadcast.
